// File: rtl/fixed_point_sign_tracker.sv
// ---------------------------------------------------------------------------
// fixed_point_sign_tracker
//
// Sign-folding wrapper for odd-symmetric fixed-point functions (tanh, sinh,
// odd polynomials). Operands are folded to their magnitude on the way into a
// non-negative-domain ALU, and the original sign is recorded in a small FIFO.
// When the ALU hands back a result (in order, any latency), the oldest sign
// is popped and re-applied.
//
// Build option:
//   FIXED_POINT_SIGN_TRACKER_SAT_EN  defined     -> negating the most negative
//                                                   value saturates to +max
//                                    not defined -> the negation wraps (raw
//                                                   two's complement)
//   The overflow flags are raised in both builds.
//
// Parameters:
//   WIDTH      data width, two's complement
//   FRAC_BITS  fractional bits (informational, no arithmetic uses it)
//   DEPTH      sign FIFO entries, >= 2
//
// Ports:
//   CLK            rising-edge clock
//   RSTN           synchronous active-low reset
//   VALUE_IN       signed operand
//   VALID_IN       operand strobe, accepted when READY_IN=1
//   READY_IN       combinational, 1 while the sign FIFO is not full
//   ABS_OUT        registered magnitude towards the ALU
//   ABS_VALID      1-cycle strobe qualifying ABS_OUT
//   ABS_OVERFLOW   operand was the most negative value (with ABS_VALID)
//   ALU_RESULT     signed result from the ALU
//   ALU_VALID      result strobe, always accepted
//   VALUE_OUT      registered sign-restored result
//   VALID_OUT      1-cycle strobe qualifying VALUE_OUT
//   OVERFLOW       negation of the result overflowed (with VALID_OUT)
//   UNDERFLOW_ERR  sticky: a result arrived while the FIFO was empty
//   COUNT          current FIFO occupancy
// ---------------------------------------------------------------------------
module fixed_point_sign_tracker #(
   parameter int WIDTH     = 8,
   parameter int FRAC_BITS = 3,
   parameter int DEPTH     = 4
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic signed [WIDTH-1:0]    VALUE_IN,
   input  logic                       VALID_IN,
   output logic                       READY_IN,
   output logic signed [WIDTH-1:0]    ABS_OUT,
   output logic                       ABS_VALID,
   output logic                       ABS_OVERFLOW,
   input  logic signed [WIDTH-1:0]    ALU_RESULT,
   input  logic                       ALU_VALID,
   output logic signed [WIDTH-1:0]    VALUE_OUT,
   output logic                       VALID_OUT,
   output logic                       OVERFLOW,
   output logic                       UNDERFLOW_ERR,
   output logic [$clog2(DEPTH+1)-1:0] COUNT
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

   // Elaboration-time parameter sanity.
   if (DEPTH < 2) begin : g_depth_chk
      $error("DEPTH must be at least 2");
   end
   if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_frac_chk
      $error("FRAC_BITS must lie in [0, WIDTH-1]");
   end

   // Two's-complement negation. Returns {overflow, value}; overflow only for
   // the most negative input, whose value then wraps or saturates.
   function automatic logic [WIDTH:0] negate_sat(input logic signed [WIDTH-1:0] x);
      logic                    ovf;
      logic signed [WIDTH-1:0] r;
      ovf = (x == MOST_NEG);
      r   = -x;
`ifdef FIXED_POINT_SIGN_TRACKER_SAT_EN
      if (ovf) r = MOST_POS;
`endif
      return {ovf, r};
   endfunction

   // FIFO state
   logic [DEPTH-1:0] sign_mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   // Stage 0: handshake decode and combinational fold / restore
   logic                    ready_p0;
   logic                    push_p0;
   logic                    pop_p0;
   logic                    underflow_p0;
   logic                    sign_in_p0;
   logic                    sign_out_p0;
   logic [WIDTH:0]          abs_neg_p0;
   logic [WIDTH:0]          res_neg_p0;
   logic signed [WIDTH-1:0] abs_p0;
   logic                    abs_ovf_p0;
   logic signed [WIDTH-1:0] res_p0;
   logic                    res_ovf_p0;

   // A full FIFO blocks the push even when a pop happens in the same cycle;
   // the ready decision is taken from the registered occupancy only.
   assign ready_p0     = (count != CW'(DEPTH));
   assign push_p0      = VALID_IN & ready_p0;
   // Pop uses pre-push occupancy, so a push into an empty FIFO is never
   // bypassed to a simultaneous return.
   assign pop_p0       = ALU_VALID & (count != '0);
   assign underflow_p0 = ALU_VALID & (count == '0);

   assign sign_in_p0   = VALUE_IN[WIDTH-1];
   assign sign_out_p0  = sign_mem[rd_ptr];

   assign abs_neg_p0   = negate_sat(VALUE_IN);
   assign abs_p0       = sign_in_p0 ? abs_neg_p0[WIDTH-1:0] : VALUE_IN;
   assign abs_ovf_p0   = sign_in_p0 & abs_neg_p0[WIDTH];

   assign res_neg_p0   = negate_sat(ALU_RESULT);
   assign res_p0       = sign_out_p0 ? res_neg_p0[WIDTH-1:0] : ALU_RESULT;
   assign res_ovf_p0   = sign_out_p0 & res_neg_p0[WIDTH];

   // Sign storage: plain memory, validity is tracked by the pointers.
   always_ff @(posedge CLK) begin
      if (push_p0) begin
         sign_mem[wr_ptr] <= sign_in_p0;
      end
   end

   // FIFO pointers, occupancy and sticky underflow
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         UNDERFLOW_ERR <= 1'b0;
      end else begin
         if (push_p0) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop_p0) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({push_p0, pop_p0})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (underflow_p0) begin
            UNDERFLOW_ERR <= 1'b1;
         end
      end
   end

   // Stage 1: registered ABS path and restored return path
   logic signed [WIDTH-1:0] abs_p1;
   logic                    abs_ovf_p1;
   logic                    abs_vld_p1;
   logic signed [WIDTH-1:0] res_p1;
   logic                    res_ovf_p1;
   logic                    vld_p1;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         abs_p1     <= '0;
         abs_ovf_p1 <= 1'b0;
         abs_vld_p1 <= 1'b0;
         res_p1     <= '0;
         res_ovf_p1 <= 1'b0;
         vld_p1     <= 1'b0;
      end else begin
         abs_vld_p1 <= push_p0;
         vld_p1     <= pop_p0;
         if (push_p0) begin
            abs_p1     <= abs_p0;
            abs_ovf_p1 <= abs_ovf_p0;
         end
         if (pop_p0) begin
            res_p1     <= res_p0;
            res_ovf_p1 <= res_ovf_p0;
         end
      end
   end

   assign READY_IN     = ready_p0;
   assign COUNT        = count;
   assign ABS_OUT      = abs_p1;
   assign ABS_OVERFLOW = abs_ovf_p1;
   assign ABS_VALID    = abs_vld_p1;
   assign VALUE_OUT    = res_p1;
   assign OVERFLOW     = res_ovf_p1;
   assign VALID_OUT    = vld_p1;

endmodule

// File: tb/tb_fixed_point_sign_tracker.sv
// ---------------------------------------------------------------------------
// Testbench for fixed_point_sign_tracker (WIDTH=8, DEPTH=4).
// Directed vector table, hand-written reset/underflow sequence, then random
// traffic compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fixed_point_sign_tracker;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);

`ifdef FIXED_POINT_SIGN_TRACKER_SAT_EN
   localparam int MIN_RES = 8'h7F;
`else
   localparam int MIN_RES = 8'h80;
`endif

   logic          CLK = 1'b0;
   logic          RSTN;
   logic [W-1:0]  VALUE_IN;
   logic          VALID_IN;
   logic          READY_IN;
   logic [W-1:0]  ABS_OUT;
   logic          ABS_VALID;
   logic          ABS_OVERFLOW;
   logic [W-1:0]  ALU_RESULT;
   logic          ALU_VALID;
   logic [W-1:0]  VALUE_OUT;
   logic          VALID_OUT;
   logic          OVERFLOW;
   logic          UNDERFLOW_ERR;
   logic [CW-1:0] COUNT;

   always #5 CLK = ~CLK;

   fixed_point_sign_tracker #(.WIDTH(W), .FRAC_BITS(3), .DEPTH(D)) dut (
      .CLK          (CLK),
      .RSTN         (RSTN),
      .VALUE_IN     (VALUE_IN),
      .VALID_IN     (VALID_IN),
      .READY_IN     (READY_IN),
      .ABS_OUT      (ABS_OUT),
      .ABS_VALID    (ABS_VALID),
      .ABS_OVERFLOW (ABS_OVERFLOW),
      .ALU_RESULT   (ALU_RESULT),
      .ALU_VALID    (ALU_VALID),
      .VALUE_OUT    (VALUE_OUT),
      .VALID_OUT    (VALID_OUT),
      .OVERFLOW     (OVERFLOW),
      .UNDERFLOW_ERR(UNDERFLOW_ERR),
      .COUNT        (COUNT)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference arithmetic on plain integers.
   function automatic int magnitude(input logic [W-1:0] v);
      int s;
      int m;
      s = int'($signed(v));
      m = (s < 0) ? -s : s;
      if (m == 128) m = MIN_RES;
      return m & 255;
   endfunction

   function automatic int restore(input bit neg, input logic [W-1:0] r);
      int s;
      int v;
      s = int'($signed(r));
      v = neg ? -s : s;
      if (v == 128) v = MIN_RES;
      return v & 255;
   endfunction

   typedef struct {
      bit         vi;
      logic [7:0] vin;
      bit         av;
      logic [7:0] ar;
      bit         e_av;
      logic [7:0] e_abs;
      bit         e_aovf;
      bit         e_vo;
      logic [7:0] e_val;
      bit         e_ovf;
      int         e_cnt;
      bit         e_rdy;
      bit         e_uf;
   } vec_t;

   vec_t vecs[20];

   bit   q[$];
   bit   m_uf;

   initial begin
      // vi  vin   av  ar     e_av e_abs      aovf e_vo e_val       ovf cnt rdy uf
      vecs[0]  = '{1, 8'hF0, 0, 8'h00, 1, 8'h10,        0, 0, 8'h00,        0, 1, 1, 0};
      vecs[1]  = '{0, 8'h00, 1, 8'h08, 0, 8'h00,        0, 1, 8'hF8,        0, 0, 1, 0};
      vecs[2]  = '{1, 8'h10, 0, 8'h00, 1, 8'h10,        0, 0, 8'h00,        0, 1, 1, 0};
      vecs[3]  = '{1, 8'hE0, 0, 8'h00, 1, 8'h20,        0, 0, 8'h00,        0, 2, 1, 0};
      vecs[4]  = '{1, 8'h00, 0, 8'h00, 1, 8'h00,        0, 0, 8'h00,        0, 3, 1, 0};
      vecs[5]  = '{1, 8'h88, 0, 8'h00, 1, 8'h78,        0, 0, 8'h00,        0, 4, 0, 0};
      vecs[6]  = '{1, 8'h55, 0, 8'h00, 0, 8'h00,        0, 0, 8'h00,        0, 4, 0, 0};
      vecs[7]  = '{1, 8'h33, 1, 8'h05, 0, 8'h00,        0, 1, 8'h05,        0, 3, 1, 0};
      vecs[8]  = '{0, 8'h00, 1, 8'h05, 0, 8'h00,        0, 1, 8'hFB,        0, 2, 1, 0};
      vecs[9]  = '{0, 8'h00, 1, 8'h00, 0, 8'h00,        0, 1, 8'h00,        0, 1, 1, 0};
      vecs[10] = '{0, 8'h00, 1, 8'h05, 0, 8'h00,        0, 1, 8'hFB,        0, 0, 1, 0};
      vecs[11] = '{1, 8'h80, 0, 8'h00, 1, 8'(MIN_RES),  1, 0, 8'h00,        0, 1, 1, 0};
      vecs[12] = '{0, 8'h00, 1, 8'h80, 0, 8'h00,        0, 1, 8'(MIN_RES),  1, 0, 1, 0};
      vecs[13] = '{1, 8'hFF, 0, 8'h00, 1, 8'h01,        0, 0, 8'h00,        0, 1, 1, 0};
      vecs[14] = '{0, 8'h00, 1, 8'h00, 0, 8'h00,        0, 1, 8'h00,        0, 0, 1, 0};
      vecs[15] = '{1, 8'h7F, 0, 8'h00, 1, 8'h7F,        0, 0, 8'h00,        0, 1, 1, 0};
      vecs[16] = '{1, 8'h81, 1, 8'h10, 1, 8'h7F,        0, 1, 8'h10,        0, 1, 1, 0};
      vecs[17] = '{0, 8'h00, 1, 8'h10, 0, 8'h00,        0, 1, 8'hF0,        0, 0, 1, 0};
      vecs[18] = '{1, 8'h40, 1, 8'h22, 1, 8'h40,        0, 0, 8'h00,        0, 1, 1, 1};
      vecs[19] = '{0, 8'h00, 1, 8'h33, 0, 8'h00,        0, 1, 8'h33,        0, 0, 1, 1};

      RSTN       = 1'b0;
      VALUE_IN   = '0;
      VALID_IN   = 1'b0;
      ALU_RESULT = '0;
      ALU_VALID  = 1'b0;
      tick();
      tick();

      chk("rst_count",     32'(COUNT),         0);
      chk("rst_ready",     32'(READY_IN),      1);
      chk("rst_abs_valid", 32'(ABS_VALID),     0);
      chk("rst_abs_out",   32'(ABS_OUT),       0);
      chk("rst_valid_out", 32'(VALID_OUT),     0);
      chk("rst_value_out", 32'(VALUE_OUT),     0);
      chk("rst_uf",        32'(UNDERFLOW_ERR), 0);

      RSTN = 1'b1;
      tick();

      // Directed vectors
      for (int i = 0; i < 20; i++) begin
         VALID_IN   = vecs[i].vi;
         VALUE_IN   = vecs[i].vin;
         ALU_VALID  = vecs[i].av;
         ALU_RESULT = vecs[i].ar;
         tick();
         chk($sformatf("v%0d_abs_valid", i), 32'(ABS_VALID), 32'(vecs[i].e_av));
         if (vecs[i].e_av) begin
            chk($sformatf("v%0d_abs_out", i),  32'(ABS_OUT),      32'(vecs[i].e_abs));
            chk($sformatf("v%0d_abs_ovf", i),  32'(ABS_OVERFLOW), 32'(vecs[i].e_aovf));
         end
         chk($sformatf("v%0d_valid_out", i), 32'(VALID_OUT), 32'(vecs[i].e_vo));
         if (vecs[i].e_vo) begin
            chk($sformatf("v%0d_value_out", i), 32'(VALUE_OUT), 32'(vecs[i].e_val));
            chk($sformatf("v%0d_overflow", i),  32'(OVERFLOW),  32'(vecs[i].e_ovf));
         end
         chk($sformatf("v%0d_count", i), 32'(COUNT),         32'(vecs[i].e_cnt));
         chk($sformatf("v%0d_ready", i), 32'(READY_IN),      32'(vecs[i].e_rdy));
         chk($sformatf("v%0d_uf", i),    32'(UNDERFLOW_ERR), 32'(vecs[i].e_uf));
      end
      VALID_IN  = 1'b0;
      ALU_VALID = 1'b0;

      // Reset mid-operation with three signs in flight
      VALID_IN = 1'b1;
      VALUE_IN = 8'h85; tick();
      VALUE_IN = 8'h12; tick();
      VALUE_IN = 8'hC0; tick();
      VALID_IN = 1'b0;
      chk("mid_count3", 32'(COUNT), 3);
      RSTN = 1'b0;
      tick();
      RSTN = 1'b1;
      chk("mid_count",     32'(COUNT),         0);
      chk("mid_ready",     32'(READY_IN),      1);
      chk("mid_abs_out",   32'(ABS_OUT),       0);
      chk("mid_abs_valid", 32'(ABS_VALID),     0);
      chk("mid_abs_ovf",   32'(ABS_OVERFLOW),  0);
      chk("mid_value_out", 32'(VALUE_OUT),     0);
      chk("mid_valid_out", 32'(VALID_OUT),     0);
      chk("mid_overflow",  32'(OVERFLOW),      0);
      chk("mid_uf",        32'(UNDERFLOW_ERR), 0);

      ALU_VALID  = 1'b1;
      ALU_RESULT = 8'h44;
      tick();
      ALU_VALID  = 1'b0;
      chk("post_rst_uf",        32'(UNDERFLOW_ERR), 1);
      chk("post_rst_valid_out", 32'(VALID_OUT),     0);
      chk("post_rst_count",     32'(COUNT),         0);
      tick();
      chk("uf_sticky", 32'(UNDERFLOW_ERR), 1);

      // Random traffic against the queue model
      RSTN = 1'b0;
      tick();
      RSTN = 1'b1;
      q.delete();
      m_uf = 1'b0;
      for (int n = 0; n < 500; n++) begin
         bit         e_rdy;
         bit         e_push;
         bit         e_pop;
         bit         e_sign;
         logic [7:0] vin;
         logic [7:0] ar;
         vin = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
         ar  = ($urandom_range(0, 7) == 0) ? 8'h80 :
               ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         VALID_IN   = ($urandom_range(0, 99) < 60);
         VALUE_IN   = vin;
         ALU_VALID  = ($urandom_range(0, 99) < 50);
         ALU_RESULT = ar;

         e_rdy  = (q.size() < D);
         e_push = VALID_IN && e_rdy;
         e_pop  = ALU_VALID && (q.size() > 0);
         e_sign = (q.size() > 0) ? q[0] : 1'b0;
         chk("rnd_ready", 32'(READY_IN), 32'(e_rdy));
         tick();

         if (ALU_VALID && q.size() == 0) m_uf = 1'b1;
         if (e_pop)  void'(q.pop_front());
         if (e_push) q.push_back(vin[7]);

         chk("rnd_abs_valid", 32'(ABS_VALID), 32'(e_push));
         if (e_push) begin
            chk("rnd_abs_out", 32'(ABS_OUT),      32'(magnitude(vin)));
            chk("rnd_abs_ovf", 32'(ABS_OVERFLOW), 32'(vin == 8'h80));
         end
         chk("rnd_valid_out", 32'(VALID_OUT), 32'(e_pop));
         if (e_pop) begin
            chk("rnd_value_out", 32'(VALUE_OUT), 32'(restore(e_sign, ar)));
            chk("rnd_overflow",  32'(OVERFLOW),  32'(e_sign && ar == 8'h80));
         end
         chk("rnd_count", 32'(COUNT),         32'(q.size()));
         chk("rnd_uf",    32'(UNDERFLOW_ERR), 32'(m_uf));
      end
      VALID_IN  = 1'b0;
      ALU_VALID = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fixed_point_sign_tracker.md
# fixed_point_sign_tracker

Sign-folding front/back end for odd-symmetric fixed-point functions such as tanh, sinh and odd polynomials. Its behaviour is specified by the bullets below.
- The input side folds each operand to its magnitude and records the original sign in an internal FIFO.
- The shared non-negative-domain ALU processes magnitudes only.
- The return side pops the recorded sign and re-applies it to each ALU result.
- The block sits directly around the sign-change stage. The ALU between its two sides may have any latency, provided it delivers results in order.

## Interface
Parameters:
- WIDTH, 8, data width, two's complement.
- FRAC_BITS, 3, fractional bits. This parameter is informational only: no arithmetic depends on it.
- DEPTH, 4, number of sign FIFO entries. Must be ≥2; any integer value is valid.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- VALUE_IN  in  WIDTH  signed operand.
- VALID_IN  in  1  operand strobe. The operand is accepted only when READY_IN=1.
- READY_IN  out  1  combinational: 1 when the FIFO is not full.
- ABS_OUT  out  WIDTH  registered magnitude sent to the ALU.
- ABS_VALID  out  1  registered 1-cycle strobe qualifying ABS_OUT.
- ABS_OVERFLOW  out  1  qualified by ABS_VALID. Set when the operand was the most negative value.
- ALU_RESULT  in  WIDTH  signed result returned from the ALU.
- ALU_VALID  in  1  result strobe. No backpressure: this is always accepted.
- VALUE_OUT  out  WIDTH  registered, sign-restored result.
- VALID_OUT  out  1  registered 1-cycle strobe qualifying VALUE_OUT.
- OVERFLOW  out  1  qualified by VALID_OUT. Set when negation of the result overflowed.
- UNDERFLOW_ERR  out  1  sticky flag: ALU_VALID arrived while the FIFO was empty.
- COUNT  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- **Accept condition.** An operand is accepted when VALID_IN & READY_IN.
  - The accepted operand's sign bit VALUE_IN[WIDTH-1] is pushed into the FIFO.
  - ABS_OUT is registered as follows:
    - Sign 0: VALUE_IN passes through unchanged.
    - Sign 1: ABS_OUT = ~VALUE_IN + 1, truncated to WIDTH bits.
- **Most negative operand.** If VALUE_IN = 100…0, ABS_OVERFLOW=1. The value of ABS_OUT for this case is set by the macro in Configuration.
- **Return path.** When ALU_VALID=1 and COUNT>0, one sign is popped.
  - Popped sign 0: VALUE_OUT = ALU_RESULT.
  - Popped sign 1: VALUE_OUT = two's-complement negation of ALU_RESULT.
  - OVERFLOW=1 only when the popped sign is 1 and ALU_RESULT = 100…0.
  - Negating zero yields zero, with OVERFLOW=0.
- **Return with empty FIFO.** When ALU_VALID=1 and COUNT=0:
  - no pop occurs;
  - VALID_OUT stays 0;
  - UNDERFLOW_ERR is set and stays set until reset.
- **FIFO structure.** Circular buffer with separate write and read pointers, each wrapping from DEPTH-1 to 0.
  - COUNT is incremented on a push only.
  - COUNT is decremented on a pop only.
  - COUNT is unchanged on a simultaneous push and pop.
- **Simultaneous push and pop.** Legal at any occupancy at which the push is allowed. When COUNT=0 and both occur in the same cycle, the pop is an underflow: the freshly pushed sign is not bypassed to the return side.
- **Full FIFO.** When COUNT=DEPTH, READY_IN=0. A pop in the same cycle does not re-enable the push in that cycle.
- **Reset.** RSTN=0 takes effect on the next clock edge and sets:
  - pointers = 0, COUNT = 0 and READY_IN = 1;
  - ABS_OUT = 0, ABS_VALID = 0 and ABS_OVERFLOW = 0;
  - VALUE_OUT = 0, VALID_OUT = 0 and OVERFLOW = 0;
  - UNDERFLOW_ERR = 0.
- **Reset mid-operation.** Signs in flight are discarded. ALU results arriving later count as underflow.

## Timing
- Input to ABS path: 1 cycle. A push at edge N gives ABS_VALID high during cycle N+1 only.
- Return to output: 1 cycle. ALU_VALID sampled at edge M gives VALID_OUT high during cycle M+1 only.
- FIFO state updates on the same edge that samples the handshake.
  - COUNT reflects a push or pop from the next cycle.
  - READY_IN falls in the cycle after the push that fills the FIFO.
- Sustained throughput: one operand per cycle on each side.
- Strobes are not held between events. Data registers keep their last value when their strobe is low.

## Configuration
Macro FIXED_POINT_SIGN_TRACKER_SAT_EN selects how both negation paths handle the most negative value, 100…0.
- **Defined:** the affected output saturates to 011…1 (+max). ABS_OVERFLOW or OVERFLOW is still asserted.
- **Not defined:** the result wraps to 100…0, the raw two's complement. The same flags are asserted.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=8 and DEPTH=4.
1. **Fold and restore round trip.**
   - Push VALUE_IN=0xF0 (-2.0) → the next cycle gives ABS_OUT=0x10 and ABS_VALID=1, with COUNT=1.
   - Return ALU_RESULT=0x08 → the next cycle gives VALUE_OUT=0xF8 and VALID_OUT=1, with COUNT=0.
2. **Back-to-back ordering.**
   - Push 0x10, 0xE0, 0x00 and 0x88 on consecutive cycles.
   - Return 0x05, 0x05, 0x00 and 0x05 → VALUE_OUT is 0x05, 0xFB, 0x00 and 0xFB in that order.
3. **Full FIFO and backpressure.**
   - Push 4 operands with no returns → READY_IN=0 and COUNT=4. A 5th VALID_IN is ignored: no ABS_VALID is produced.
   - One return → READY_IN=1 in the following cycle.
4. **Most negative value.**
   - Push 0x80 → ABS_OVERFLOW=1. ABS_OUT=0x7F with SAT_EN, or 0x80 without it.
   - Pop a negative sign with ALU_RESULT=0x80 → OVERFLOW=1. VALUE_OUT follows the same rule.
5. **Underflow.** ALU_VALID with COUNT=0 → UNDERFLOW_ERR=1, with no VALID_OUT and COUNT=0. The flag persists through further traffic until RSTN=0.
6. **Reset mid-operation.**
   - With COUNT=3, assert RSTN=0 for one edge → COUNT=0, READY_IN=1 and all outputs 0.
   - A following ALU_VALID raises UNDERFLOW_ERR.
